// File: rtl/data_block_scheduler.sv
// Stage/completion scheduler between the input block FIFO and the AES round unit.
// Returning blocks win the stage over fresh FIFO blocks; finished blocks drain through a handshaked register.
module data_block_scheduler #(
  parameter int BLOCK_W      = 128,
  parameter int STATE_W      = 5,
  parameter int FINAL_STATE  = 10,
  parameter int MAX_INFLIGHT = 4,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fifo_empty,
  input  logic [BLOCK_W-1:0] i_fifo_in,
  output logic               o_read_fifo,
  input  logic               i_round_valid,
  input  logic [BLOCK_W-1:0] i_round_block,
  input  logic [STATE_W-1:0] i_round_state,
  output logic               o_round_ready,
  output logic               o_valid,
  output logic [BLOCK_W-1:0] o_block_out,
  output logic [STATE_W-1:0] o_state_out,
  input  logic               i_stage_ready,
  output logic               o_done_valid,
  output logic [BLOCK_W-1:0] o_done_block,
  input  logic               i_done_ready,
  output logic [CNT_W-1:0]   o_inflight
);

  localparam logic [STATE_W-1:0] FINAL_ST = STATE_W'(FINAL_STATE);
  localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_INFLIGHT);

  logic             s_can_load;
  logic             d_can_load;
  logic             fin;
  logic             fb_take;
  logic             done_take;
  logic [CNT_W-1:0] inflight_nxt;

  assign s_can_load = !o_valid || i_stage_ready;
  assign d_can_load = !o_done_valid || i_done_ready;

  // States beyond FINAL_STATE are illegal; treating them as final keeps them from circulating forever.
  assign fin = (i_round_state >= FINAL_ST);

  assign fb_take   = i_round_valid && !fin && s_can_load;
  assign done_take = i_round_valid && fin && d_can_load;

  // Handshake outputs are forced low during reset so nothing is popped or accepted.
  assign o_round_ready = !i_rst && (fin ? d_can_load : s_can_load);
  assign o_read_fifo   = !i_rst && !i_fifo_empty && s_can_load &&
                         !(i_round_valid && !fin) && (o_inflight < MAX_CNT);

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    inflight_nxt = o_inflight;
    if (o_read_fifo && !done_take) begin
      inflight_nxt = o_inflight + CNT_W'(1);
    end else if (!o_read_fifo && done_take && (o_inflight != '0)) begin
      inflight_nxt = o_inflight - CNT_W'(1);
    end
  end

  // NOTE: data registers are reset too, so every output reads zero while reset is asserted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_inflight <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
      o_inflight <= inflight_nxt;
    end
  end

  // Stage register: feedback first, then injection; data is held when valid drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_block_out <= '0;
      o_state_out <= '0;
    end else if (fb_take) begin
      o_valid     <= 1'b1;
      o_block_out <= i_round_block;
      o_state_out <= i_round_state;
    end else if (o_read_fifo) begin
      o_valid     <= 1'b1;
      o_block_out <= i_fifo_in;
      o_state_out <= '0;
    end else if (i_stage_ready) begin
      o_valid     <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_done_valid <= 1'b0;
      o_done_block <= '0;
    end else if (done_take) begin
      o_done_valid <= 1'b1;
      o_done_block <= i_round_block;
    end else if (i_done_ready) begin
      o_done_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_block_scheduler.sv
// Self-checking bench for data_block_scheduler: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_data_block_scheduler;

  localparam int BW = 128;
  localparam int SW = 5;
  localparam int FS = 10;
  localparam int MI = 4;
  localparam int CW = $clog2(MI + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [BW-1:0] fifo_in;
  logic          read_fifo;
  logic          round_valid;
  logic [BW-1:0] round_block;
  logic [SW-1:0] round_state;
  logic          round_ready;
  logic          valid;
  logic [BW-1:0] block_out;
  logic [SW-1:0] state_out;
  logic          stage_ready;
  logic          done_valid;
  logic [BW-1:0] done_block;
  logic          done_ready;
  logic [CW-1:0] inflight;

  int checks   = 0;
  int failures = 0;

  data_block_scheduler #(
    .BLOCK_W(BW), .STATE_W(SW), .FINAL_STATE(FS), .MAX_INFLIGHT(MI)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_fifo_empty(fifo_empty), .i_fifo_in(fifo_in), .o_read_fifo(read_fifo),
    .i_round_valid(round_valid), .i_round_block(round_block), .i_round_state(round_state),
    .o_round_ready(round_ready),
    .o_valid(valid), .o_block_out(block_out), .o_state_out(state_out), .i_stage_ready(stage_ready),
    .o_done_valid(done_valid), .o_done_block(done_block), .i_done_ready(done_ready),
    .o_inflight(inflight)
  );

  always #5 clk = ~clk;

  task automatic check_w(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [BW-1:0] fi, input logic rv,
                       input logic [BW-1:0] rb, input logic [SW-1:0] rs,
                       input logic sr, input logic dr);
    fifo_empty  = e;
    fifo_in     = fi;
    round_valid = rv;
    round_block = rb;
    round_state = rs;
    stage_ready = sr;
    done_ready  = dr;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-step vectors, each applied from the reset state with both ready inputs high.
  typedef struct {
    logic          e;
    logic          rv;
    logic [SW-1:0] rs;
    logic          x_rd;
    logic          x_rr;
    logic          x_v;
    logic [SW-1:0] x_st;
    int            x_src;   // 0: zero, 1: FIFO block, 2: returned block
    logic          x_dv;
    int            x_cnt;
  } vec_t;

  localparam logic [BW-1:0] FIFO_PAT = {4{32'h1234_5678}};
  localparam logic [BW-1:0] RET_PAT  = {4{32'h9abc_def0}};
  localparam logic [BW-1:0] A5_PAT   = {16{8'ha5}};

  vec_t vecs[8];

  // Reference model state: the scheduler seen as a set of transfers.
  logic          m_valid, m_dv;
  logic [BW-1:0] m_blk, m_dblk;
  logic [SW-1:0] m_st;
  int            m_cnt;

  task automatic model_reset();
    m_valid = 1'b0; m_dv = 1'b0; m_blk = '0; m_dblk = '0; m_st = '0; m_cnt = 0;
  endtask

  initial begin
    logic [BW-1:0] exp_blk;
    rst = 1'b1;
    drive(1'b1, '0, 1'b0, '0, '0, 1'b1, 1'b1);

    //           e    rv   rs     rd   rr   v    st     src dv   cnt
    vecs[0] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd0, 0, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 5'd0, 1, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b1, 5'd3,  1'b0, 1'b1, 1'b1, 5'd3, 2, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b1, 5'd10, 1'b1, 1'b1, 1'b1, 5'd0, 1, 1'b1, 0};
    vecs[4] = '{1'b1, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0, 5'd0, 0, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0, 5'd0, 0, 1'b1, 0};
    vecs[6] = '{1'b1, 1'b1, 5'd9,  1'b0, 1'b1, 1'b1, 5'd9, 2, 1'b0, 0};
    vecs[7] = '{1'b0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b1, 5'd0, 1, 1'b0, 1};

    // Reset state
    do_reset();
    check_b("rst_valid", valid, 1'b0);
    check_b("rst_done_valid", done_valid, 1'b0);
    check_n("rst_inflight", int'(inflight), 0);
    check_w("rst_block", block_out, '0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(vecs[i].e, FIFO_PAT, vecs[i].rv, RET_PAT, vecs[i].rs, 1'b1, 1'b1);
      #1;
      check_b($sformatf("vec%0d_read_fifo", i), read_fifo, vecs[i].x_rd);
      check_b($sformatf("vec%0d_round_ready", i), round_ready, vecs[i].x_rr);
      tick();
      exp_blk = (vecs[i].x_src == 1) ? FIFO_PAT : (vecs[i].x_src == 2) ? RET_PAT : '0;
      check_b($sformatf("vec%0d_valid", i), valid, vecs[i].x_v);
      check_n($sformatf("vec%0d_state", i), int'(state_out), int'(vecs[i].x_st));
      check_w($sformatf("vec%0d_block", i), block_out, exp_blk);
      check_b($sformatf("vec%0d_done_valid", i), done_valid, vecs[i].x_dv);
      check_w($sformatf("vec%0d_done_block", i), done_block, vecs[i].x_dv ? RET_PAT : '0);
      check_n($sformatf("vec%0d_inflight", i), int'(inflight), vecs[i].x_cnt);
    end

    // Injection latency
    do_reset();
    drive(1'b0, A5_PAT, 1'b0, '0, '0, 1'b1, 1'b1);
    #1 check_b("inj_read_fifo", read_fifo, 1'b1);
    tick();
    check_b("inj_valid", valid, 1'b1);
    check_w("inj_block", block_out, A5_PAT);
    check_n("inj_state", int'(state_out), 0);
    check_n("inj_inflight", int'(inflight), 1);

    // Returned block pre-empts the FIFO
    drive(1'b0, FIFO_PAT, 1'b1, RET_PAT, 5'd3, 1'b1, 1'b1);
    #1 check_b("pri_read_fifo", read_fifo, 1'b0);
    check_b("pri_round_ready", round_ready, 1'b1);
    tick();
    check_n("pri_state", int'(state_out), 3);
    check_w("pri_block", block_out, RET_PAT);
    check_n("pri_inflight", int'(inflight), 1);

    // Credit cap, then a completion frees a credit
    do_reset();
    drive(1'b0, FIFO_PAT, 1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < MI; i++) begin
      #1 check_b($sformatf("cap_read_fifo%0d", i), read_fifo, 1'b1);
      tick();
    end
    check_n("cap_inflight", int'(inflight), MI);
    #1 check_b("cap_read_blocked", read_fifo, 1'b0);
    drive(1'b0, FIFO_PAT, 1'b1, 128'hd1, 5'd10, 1'b1, 1'b1);
    #1 check_b("cap_round_ready", round_ready, 1'b1);
    check_b("cap_read_still_blocked", read_fifo, 1'b0);
    tick();
    check_b("cap_done_valid", done_valid, 1'b1);
    check_w("cap_done_block", done_block, 128'hd1);
    check_n("cap_inflight_dec", int'(inflight), MI - 1);
    drive(1'b0, FIFO_PAT, 1'b0, '0, '0, 1'b1, 1'b0);
    #1 check_b("cap_resume", read_fifo, 1'b1);
    fifo_empty = 1'b1;

    // Done back-pressure
    drive(1'b1, FIFO_PAT, 1'b1, 128'hd2, 5'd10, 1'b1, 1'b0);
    #1 check_b("dst_round_ready", round_ready, 1'b0);
    tick();
    check_b("dst_done_valid", done_valid, 1'b1);
    check_w("dst_done_hold", done_block, 128'hd1);
    check_n("dst_inflight", int'(inflight), MI - 1);
    done_ready = 1'b1;
    #1 check_b("dst_round_ready_rel", round_ready, 1'b1);
    tick();
    check_w("dst_done_block", done_block, 128'hd2);
    check_n("dst_inflight_dec", int'(inflight), MI - 2);
    drive(1'b1, FIFO_PAT, 1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    check_b("dst_done_drain", done_valid, 1'b0);

    // Concurrent injection and completion
    drive(1'b0, 128'hf5, 1'b1, 128'hd3, 5'd10, 1'b1, 1'b1);
    #1 check_b("cc_read_fifo", read_fifo, 1'b1);
    check_b("cc_round_ready", round_ready, 1'b1);
    tick();
    check_b("cc_valid", valid, 1'b1);
    check_n("cc_state", int'(state_out), 0);
    check_w("cc_block", block_out, 128'hf5);
    check_b("cc_done_valid", done_valid, 1'b1);
    check_w("cc_done_block", done_block, 128'hd3);
    check_n("cc_inflight", int'(inflight), 2);

    // Asynchronous reset mid-stream
    drive(1'b0, 128'hf6, 1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_b("ar_valid", valid, 1'b0);
    check_b("ar_done_valid", done_valid, 1'b0);
    check_n("ar_inflight", int'(inflight), 0);
    check_w("ar_block", block_out, '0);
    check_n("ar_state", int'(state_out), 0);
    check_w("ar_done_block", done_block, '0);
    check_b("ar_read_fifo", read_fifo, 1'b0);
    tick();
    rst = 1'b0;
    stage_ready = 1'b1;
    #1 check_b("ar_resume_read", read_fifo, 1'b1);
    tick();
    check_b("ar_resume_valid", valid, 1'b1);
    check_w("ar_resume_block", block_out, 128'hf6);
    check_n("ar_resume_inflight", int'(inflight), 1);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic          e, rv, sr, dr, fin, s_free, d_free, x_rd, x_rr;
      logic [BW-1:0] fi, rb;
      logic [SW-1:0] rs;
      if (cyc % 700 == 699) begin
        do_reset();
        model_reset();
      end
      e  = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 1) == 1);
      sr = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 4) < 3);
      rs = SW'($urandom_range(0, 12));
      fi = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(e, fi, rv, rb, rs, sr, dr);

      fin    = (int'(rs) >= FS);
      s_free = !m_valid || sr;
      d_free = !m_dv || dr;
      x_rr   = fin ? d_free : s_free;
      x_rd   = !e && s_free && !(rv && !fin) && (m_cnt < MI);
      #1;
      check_b("rnd_read_fifo", read_fifo, x_rd);
      check_b("rnd_round_ready", round_ready, x_rr);

      if (rv && !fin && s_free) begin
        m_valid = 1'b1; m_blk = rb; m_st = rs;
      end else if (x_rd) begin
        m_valid = 1'b1; m_blk = fi; m_st = '0;
      end else if (sr) begin
        m_valid = 1'b0;
      end
      if (x_rd) m_cnt++;
      if (rv && fin && d_free) begin
        m_dv = 1'b1; m_dblk = rb;
        if (m_cnt > 0) m_cnt--;
      end else if (dr) begin
        m_dv = 1'b0;
      end

      tick();
      check_b("rnd_valid", valid, m_valid);
      check_w("rnd_block", block_out, m_blk);
      check_n("rnd_state", int'(state_out), int'(m_st));
      check_b("rnd_done_valid", done_valid, m_dv);
      check_w("rnd_done_block", done_block, m_dblk);
      check_n("rnd_inflight", int'(inflight), m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_block_scheduler.md
# data_block_scheduler

Registered, parametrised successor to the AES combinational data-block select. It sits between the input block FIFO and the AES round unit, and it arbitrates each cycle between a returning round block and a new FIFO block. Fresh blocks are injected with round state 0, and an in-flight credit counter caps how many blocks circulate at once. Blocks that reach the final round state are peeled off into a handshaked completion register.

## Interface
Parameters:
- BLOCK_W, 128, block width in bits.
- STATE_W, 5, round-state width.
- FINAL_STATE, 10, round-state value at which a returning block is complete.
- MAX_INFLIGHT, 4, maximum blocks between injection and completion (≥1).

Ports:
- i_clk  in  1  clock; every register updates on its rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_fifo_empty  in  1  input FIFO has no data.
- i_fifo_in  in  BLOCK_W  FIFO head data (show-ahead; valid whenever !i_fifo_empty).
- o_read_fifo  out  1  pop FIFO head this cycle.
- i_round_valid  in  1  round unit returns a block.
- i_round_block  in  BLOCK_W  returned block.
- i_round_state  in  STATE_W  returned block's round state.
- o_round_ready  out  1  returned block accepted this cycle.
- o_valid  out  1  stage register holds a block for the round unit.
- o_block_out  out  BLOCK_W  stage block.
- o_state_out  out  STATE_W  stage round state.
- i_stage_ready  in  1  round unit takes the stage block this cycle.
- o_done_valid  out  1  completion register holds a finished block.
- o_done_block  out  BLOCK_W  finished block.
- i_done_ready  in  1  downstream takes the finished block.
- o_inflight  out  $clog2(MAX_INFLIGHT+1)  current in-flight count.

## Operation
- s_can_load = !o_valid | i_stage_ready.
- d_can_load = !o_done_valid | i_done_ready.
- fin = i_round_state >= FINAL_STATE. Values above FINAL_STATE are illegal and are treated as final.
- o_round_ready = fin ? d_can_load : s_can_load. It never depends on i_round_valid.
- fb_take = i_round_valid & !fin & s_can_load.
- done_take = i_round_valid & fin & d_can_load.
- o_read_fifo = !i_fifo_empty & s_can_load & !(i_round_valid & !fin) & (o_inflight < MAX_INFLIGHT).
- Priority: a continuing returned block always wins the stage over the FIFO, so no in-flight block is ever dropped. A final block never blocks injection in the same cycle.
- Stage register, on edge:
  - fb_take: load {1, i_round_block, i_round_state}. The state passes through unchanged; the round unit increments it.
  - else o_read_fifo: load {1, i_fifo_in, 0}.
  - else if i_stage_ready: o_valid←0.
  - else: hold.
- Completion register, on edge:
  - done_take: load {1, i_round_block}.
  - else if i_done_ready: o_done_valid←0.
  - else: hold.
- Counter: +1 on o_read_fifo, −1 on done_take, unchanged when both occur. It never exceeds MAX_INFLIGHT and never underflows. A done_take at count 0 is a protocol error; the counter saturates at 0.
- Reset (any time, including mid-operation) clears all in-flight tracking:
  - o_valid, o_done_valid, o_inflight = 0.
  - o_block_out, o_state_out, o_done_block = 0.
  - o_read_fifo low while i_rst is asserted.
- Data registers load only on the transfers above; they are not cleared when valid drops.

## Timing
- Injection latency: o_read_fifo in cycle N → o_valid with state 0 in N+1.
- Feedback latency: fb_take in N → o_valid in N+1.
- Completion latency: done_take in N → o_done_valid in N+1.
- Throughput: one stage load and one completion per cycle, concurrently. Full rate holds with i_stage_ready and i_done_ready tied high.
- o_read_fifo, o_round_ready: combinational from registers and i_fifo_empty, i_round_valid, i_round_state, i_stage_ready, i_done_ready.
- Stage stall (o_valid & !i_stage_ready): no injection and no feedback acceptance; all stage outputs stable.
- Done stall (o_done_valid & !i_done_ready): final blocks back-pressured; continuing blocks and injection unaffected.

## Test plan
- Reset, then FIFO holds 0xA5..A5 with i_stage_ready=1 → o_read_fifo=1 in cycle 1; cycle 2: o_valid=1, o_block_out=0xA5..A5, o_state_out=0, o_inflight=1.
- FIFO non-empty while i_round_valid=1, state=3 → o_read_fifo=0, o_round_ready=1; next cycle o_state_out=3, o_block_out=returned block, FIFO untouched.
- Inject 4 blocks with MAX_INFLIGHT=4 and nothing returned → o_inflight=4 and o_read_fifo stays 0. Return state 10 with i_done_ready=1 → o_done_valid next cycle, o_inflight=3, injection resumes.
- i_done_ready=0 with o_done_valid=1, then return state=10 → o_round_ready=0 and the block is held. Raise i_done_ready → accepted; o_done_block updates one cycle later.
- Same cycle: return state=10 with done free, FIFO non-empty, stage free → both taken; o_inflight unchanged; o_valid(state 0) and o_done_valid both set next cycle.
- Assert i_rst mid-stream with o_valid=1, o_done_valid=1, o_inflight=2 → all outputs 0 immediately, before the next clock edge; normal injection resumes after release.
